riscv_core_fetch_queue: RTL and testbench

Decoupling queue between the instruction-memory response path and the Decode stage of the 5-stage bypassed RISC-V core. Buffers fetched {pc, inst} pairs so imem latency and Decode stalls do not stall each other. On a redirect (branch taken in X, jump or jump-register resolved in D) it squashes all buffered entries. Using a 1-bit epoch, it also discards stale responses that arrive after the squash.

---
 rtl/riscv_core_fetch_queue_pkg.sv | 13 +
 rtl/riscv_core_fetch_queue_storage.sv | 27 ++
 rtl/riscv_core_fetch_queue.sv | 120 ++++++++++++
 tb/tb_riscv_core_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_fetch_queue_pkg.sv
// Shared core constants and the fetch-queue entry type.
package riscv_core_fetch_queue_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0008_0000;
  localparam int          FQ_DEPTH     = 4;
  localparam int          EPOCH_W      = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/riscv_core_fetch_queue_storage.sv
// DEPTH x 64-bit entry array: one synchronous write port, one asynchronous read port.
module riscv_core_fetch_queue_storage
  import riscv_core_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [PW-1:0]   i_waddr,
  input  fq_entry_t       i_wdata,
  input  logic [PW-1:0]   i_raddr,
  output fq_entry_t       o_rdata
);

  fq_entry_t r_mem [DEPTH];

  // Entry write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/riscv_core_fetch_queue.sv
// Fetch-to-Decode decoupling queue with epoch-based squash of stale imem responses.
// Optional same-cycle empty-queue bypass is enabled by defining RISCV_FETCHQ_BYPASS_EN.
module riscv_core_fetch_queue
  import riscv_core_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enq_val,
  output logic                     o_enq_rdy,
  input  logic [31:0]              i_enq_pc,
  input  logic [31:0]              i_enq_inst,
  input  logic [EPOCH_W-1:0]       i_enq_epoch,
  output logic                     o_deq_val,
  input  logic                     i_deq_rdy,
  output logic [31:0]              o_deq_pc,
  output logic [31:0]              o_deq_inst,
  input  logic                     i_flush,
  output logic [EPOCH_W-1:0]       o_cur_epoch,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] ZERO_PTR = PW'(0);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic [EPOCH_W-1:0] r_epoch;

  logic               w_enq_rdy;
  logic               w_empty;
  logic               w_enq_fire;
  logic               w_byp;
  logic               w_deq_val;
  logic               w_deq_q;
  logic               w_we;
  logic [CW-1:0]      w_count_nxt;
  fq_entry_t          w_wdata;
  fq_entry_t          w_rdata;

  // enq_rdy depends only on registered occupancy, never on deq_rdy.
  assign w_enq_rdy = (r_count != FULL_CNT) && !reset;
  assign w_empty   = (r_count == ZERO_CNT);
  assign w_wdata   = '{pc: i_enq_pc, inst: i_enq_inst};

  // Handshake qualification, bypass selection and head presentation.
  always_comb begin
    w_enq_fire = i_enq_val && w_enq_rdy && !i_flush && (i_enq_epoch == r_epoch);
`ifdef RISCV_FETCHQ_BYPASS_EN
    w_byp = w_empty && w_enq_fire;
`else
    w_byp = 1'b0;
`endif
    w_deq_val = (!w_empty || w_byp) && !i_flush && !reset;
    w_deq_q   = !w_empty && !i_flush && !reset && i_deq_rdy;
    // A bypassed entry consumed this cycle never touches storage.
    w_we      = w_enq_fire && !(w_byp && i_deq_rdy);
    if (w_byp) begin
      o_deq_pc   = i_enq_pc;
      o_deq_inst = i_enq_inst;
    end else begin
      o_deq_pc   = w_rdata.pc;
      o_deq_inst = w_rdata.inst;
    end
  end

  // Next occupancy from the write/dequeue pair.
  always_comb begin
    case ({w_we, w_deq_q})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and epoch state; flush outranks all traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= ZERO_PTR;
      r_tail  <= ZERO_PTR;
      r_count <= ZERO_CNT;
      r_epoch <= {EPOCH_W{1'b0}};
    end else if (i_flush) begin
      r_head  <= ZERO_PTR;
      r_tail  <= ZERO_PTR;
      r_count <= ZERO_CNT;
      r_epoch <= ~r_epoch;
    end else begin
      r_head  <= w_deq_q ? (r_head + ONE_PTR) : r_head;
      r_tail  <= w_we    ? (r_tail + ONE_PTR) : r_tail;
      r_count <= w_count_nxt;
      r_epoch <= r_epoch;
    end
  end

  riscv_core_fetch_queue_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign o_enq_rdy   = w_enq_rdy;
  assign o_deq_val   = w_deq_val;
  assign o_cur_epoch = r_epoch;
  assign o_count     = r_count;

endmodule

// File: tb/tb_riscv_core_fetch_queue.sv
// Directed self-checking bench for riscv_core_fetch_queue (default or bypass build).
module tb_riscv_core_fetch_queue;

`ifdef RISCV_FETCHQ_BYPASS_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enq_val;
  logic        o_enq_rdy;
  logic [31:0] i_enq_pc;
  logic [31:0] i_enq_inst;
  logic [0:0]  i_enq_epoch;
  logic        o_deq_val;
  logic        i_deq_rdy;
  logic [31:0] o_deq_pc;
  logic [31:0] o_deq_inst;
  logic        i_flush;
  logic [0:0]  o_cur_epoch;
  logic [2:0]  o_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_core_fetch_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_enq_val   (i_enq_val),
    .o_enq_rdy   (o_enq_rdy),
    .i_enq_pc    (i_enq_pc),
    .i_enq_inst  (i_enq_inst),
    .i_enq_epoch (i_enq_epoch),
    .o_deq_val   (o_deq_val),
    .i_deq_rdy   (i_deq_rdy),
    .o_deq_pc    (o_deq_pc),
    .o_deq_inst  (o_deq_inst),
    .i_flush     (i_flush),
    .o_cur_epoch (o_cur_epoch),
    .o_count     (o_count)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] pc, input logic ep);
    i_enq_val   = v;
    i_enq_pc    = pc;
    i_enq_inst  = pc ^ 32'h0000_0013;
    i_enq_epoch = ep;
  endtask

  int        lat;
  int        mcount;
  int        sent;
  int        recv;
  logic      acc;
  logic      exp_dv;
  logic [31:0] q[$];
  logic [31:0] seq_pc [3];

  initial begin
    reset = 1'b1; i_flush = 1'b0; i_deq_rdy = 1'b0;
    drive_enq(1'b0, 32'h0, 1'b0);
    tick(); tick();
    @(negedge clk);
    check_value("rst_enq_rdy", {31'b0, o_enq_rdy}, 32'd0);
    check_value("rst_deq_val", {31'b0, o_deq_val}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_value("post_rst_enq_rdy", {31'b0, o_enq_rdy}, 32'd1);
    check_value("post_rst_count", {29'b0, o_count}, 32'd0);
    check_value("post_rst_epoch", {31'b0, o_cur_epoch}, 32'd0);
    tick();

    // Single entry latency
    i_deq_rdy = 1'b1;
    i_enq_val = 1'b1; i_enq_pc = 32'h0008_0000; i_enq_inst = 32'h0000_0013; i_enq_epoch = 1'b0;
    lat = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (lat < 0 && o_deq_val) begin
        lat = c;
        check_value("t1_pc", o_deq_pc, 32'h0008_0000);
        check_value("t1_inst", o_deq_inst, 32'h0000_0013);
      end
      tick();
      i_enq_val = 1'b0;
    end
    check_value("t1_latency", lat, EXP_LAT);
    @(negedge clk);
    check_value("t1_count", {29'b0, o_count}, 32'd0);
    tick();

    // Fill to full, then full queue refuses despite same-cycle dequeue
    i_deq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h0008_0000 + 32'(4 * i), 1'b0);
      tick();
    end
    drive_enq(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_value("t2_full_count", {29'b0, o_count}, 32'd4);
    check_value("t2_full_rdy", {31'b0, o_enq_rdy}, 32'd0);
    i_deq_rdy = 1'b1;
    drive_enq(1'b1, 32'h0008_0099, 1'b0);
    #1;
    check_value("t2_rdy_held_low", {31'b0, o_enq_rdy}, 32'd0);
    check_value("t2_head0", o_deq_pc, 32'h0008_0000);
    check_value("t2_head0_inst", o_deq_inst, 32'h0008_0013);
    tick();
    drive_enq(1'b0, 32'h0, 1'b0);
    seq_pc[0] = 32'h0008_0004; seq_pc[1] = 32'h0008_0008; seq_pc[2] = 32'h0008_000C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("t2_fifo_val", {31'b0, o_deq_val}, 32'd1);
      check_value("t2_fifo_pc", o_deq_pc, seq_pc[i]);
      tick();
    end
    @(negedge clk);
    check_value("t2_drained", {29'b0, o_count}, 32'd0);
    tick();

    // Flush with simultaneous enqueue
    i_deq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'h0008_0020 + 32'(4 * i), 1'b0);
      tick();
    end
    i_flush = 1'b1;
    drive_enq(1'b1, 32'h0008_0030, 1'b0);
    @(negedge clk);
    check_value("t3_flush_deq_val", {31'b0, o_deq_val}, 32'd0);
    tick();
    i_flush = 1'b0;
    drive_enq(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_value("t3_count", {29'b0, o_count}, 32'd0);
    check_value("t3_epoch", {31'b0, o_cur_epoch}, 32'd1);
    check_value("t3_deq_val", {31'b0, o_deq_val}, 32'd0);
    tick();

    // Stale response dropped, fresh one delivered
    drive_enq(1'b1, 32'h0008_0010, 1'b0);
    @(negedge clk);
    check_value("t4_stale_rdy", {31'b0, o_enq_rdy}, 32'd1);
    tick();
    drive_enq(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_value("t4_stale_count", {29'b0, o_count}, 32'd0);
    check_value("t4_stale_deq_val", {31'b0, o_deq_val}, 32'd0);
    tick();
    i_deq_rdy = 1'b1;
    drive_enq(1'b1, 32'h0008_0100, 1'b1);
    lat = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (lat < 0 && o_deq_val) begin
        lat = c;
        check_value("t4_fresh_pc", o_deq_pc, 32'h0008_0100);
      end
      tick();
      i_enq_val = 1'b0;
    end
    check_value("t4_latency", lat, EXP_LAT);
    check_value("t4_count", {29'b0, o_count}, 32'd0);

    // Wrap-around stream with alternating deq_rdy, scoreboard model
    mcount = 0; sent = 0; recv = 0;
    for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
      i_deq_rdy = cyc[0];
      drive_enq(sent < 10, 32'h0008_0400 + 32'(4 * sent), 1'b1);
      @(negedge clk);
      check_value("t5_enq_rdy", {31'b0, o_enq_rdy}, {31'b0, (mcount != 4)});
      acc = i_enq_val && (mcount != 4);
      exp_dv = (mcount != 0) || (EXP_LAT == 0 && acc);
      if (acc) begin
        q.push_back(i_enq_pc);
        sent++;
      end
      check_value("t5_deq_val", {31'b0, o_deq_val}, {31'b0, exp_dv});
      if (exp_dv && i_deq_rdy && q.size() > 0) begin
        check_value("t5_pc_order", o_deq_pc, q.pop_front());
        recv++;
      end
      mcount = q.size();
      tick();
    end
    drive_enq(1'b0, 32'h0, 1'b1);
    check_value("t5_received", recv, 32'd10);
    @(negedge clk);
    check_value("t5_final_count", {29'b0, o_count}, 32'd0);
    tick();

    // Reset mid-operation clears contents and epoch
    i_deq_rdy = 1'b0;
    drive_enq(1'b1, 32'h0008_0500, 1'b1);
    tick();
    drive_enq(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_value("t6_rst_deq_val", {31'b0, o_deq_val}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_value("t6_count", {29'b0, o_count}, 32'd0);
    check_value("t6_epoch", {31'b0, o_cur_epoch}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
